// File: rtl/hack_ram_loader.sv
// Byte-stream loader for the Hack data RAM: packs bytes big-endian into words and fills a region.
// Define HACK_LOADER_CHECKSUM_EN to require a trailing 16-bit sum word after the data.
module hack_ram_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              ram_load,
  output logic [15:0]       ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy,
  output logic              done,
  output logic              csum_err
);

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WRITE,
`ifdef HACK_LOADER_CHECKSUM_EN
    CSUM_HI,
    CSUM_LO,
`endif
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   remain_reg;
  logic [7:0]        hi_reg;
  logic [15:0]       ram_in_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic              byte_take;
  logic              start_take;

  assign byte_take  = byte_valid & byte_ready;
  assign start_take = start & (state_reg == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    byte_ready = 1'b0;
    ram_load   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (word_count == '0) ? DONE : HI;
      end
      HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = LO;
      end
      LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = WRITE;
      end
      WRITE: begin
        ram_load = 1'b1;
        // remain_reg still holds the pre-decrement count here
        if (remain_reg > (ADDR_W+1)'(1)) state_next = HI;
`ifdef HACK_LOADER_CHECKSUM_EN
        else                             state_next = CSUM_HI;
`else
        else                             state_next = DONE;
`endif
      end
`ifdef HACK_LOADER_CHECKSUM_EN
      CSUM_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = CSUM_LO;
      end
      CSUM_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_next = DONE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write-port registers load with the low byte so they are stable for the whole WRITE cycle
  // and hold afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_reg     <= '0;
      remain_reg   <= '0;
      hi_reg       <= '0;
      ram_in_reg   <= '0;
      ram_addr_reg <= '0;
    end else begin
      if (start_take) begin
        addr_reg   <= base_addr;
        remain_reg <= word_count;
      end
      if (byte_take && state_reg == HI) hi_reg <= byte_data;
      if (byte_take && state_reg == LO) begin
        ram_in_reg   <= {hi_reg, byte_data};
        ram_addr_reg <= addr_reg;
      end
      if (state_reg == WRITE) begin
        addr_reg   <= addr_reg + 1'b1;
        remain_reg <= remain_reg - 1'b1;
      end
    end
  end

  assign ram_in   = ram_in_reg;
  assign ram_addr = ram_addr_reg;

`ifdef HACK_LOADER_CHECKSUM_EN
  logic [15:0] sum_reg;
  logic [7:0]  csum_hi_reg;
  logic        csum_err_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_reg      <= '0;
      csum_hi_reg  <= '0;
      csum_err_reg <= 1'b0;
    end else begin
      if (start_take) begin
        sum_reg      <= '0;
        csum_err_reg <= 1'b0;
      end
      if (state_reg == WRITE) sum_reg <= sum_reg + ram_in_reg;
      if (byte_take && state_reg == CSUM_HI) csum_hi_reg <= byte_data;
      if (byte_take && state_reg == CSUM_LO) csum_err_reg <= ({csum_hi_reg, byte_data} != sum_reg);
    end
  end

  assign csum_err = csum_err_reg;
`else
  assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_hack_ram_loader.sv
// Randomized bench for hack_ram_loader: expected writes, byte consumption and done timing
// are derived from the word list of each load.
module tb_hack_ram_loader;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef HACK_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              ram_load;
  logic [15:0]       ram_in;
  logic [ADDR_W-1:0] ram_addr;
  logic              busy;
  logic              done;
  logic              csum_err;

  hack_ram_loader #(.ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .ram_load   (ram_load),
    .ram_in     (ram_in),
    .ram_addr   (ram_addr),
    .busy       (busy),
    .done       (done),
    .csum_err   (csum_err)
  );

  always #5 clock = ~clock;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] words_q[$];
  logic [7:0]  byte_q[$];
  int          exp_addr_q[$];
  logic [15:0] exp_data_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {29'd0, ram_load, ram_in, ram_addr, byte_ready, busy, done, csum_err};
  endfunction

  // One load of words_q at base. Inputs change on the falling edge; byte_ready seen there is the
  // value the next rising edge uses, so a driven byte is known to be accepted immediately.
  task automatic run_load(input string name, input int base, input int gap_pct,
                          input bit mid_start, input bit bad_csum, input int rst_after);
    int          cnt, idx, writes, dones, cyc, post, last_wr, last_acc, ref_cyc, exp_consumed;
    logic [15:0] sum;
    logic [15:0] csum_word;
    bit          exp_err, stop, rst_hit, quiet;
    cnt = words_q.size();
    byte_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    sum = 16'h0;
    foreach (words_q[i]) begin
      byte_q.push_back(words_q[i][15:8]);
      byte_q.push_back(words_q[i][7:0]);
      exp_addr_q.push_back((base + i) % DEPTH);
      exp_data_q.push_back(words_q[i]);
      sum = sum + words_q[i];
    end
    csum_word = sum + (bad_csum ? 16'd1 : 16'd0);
    byte_q.push_back(csum_word[15:8]);
    byte_q.push_back(csum_word[7:0]);
    byte_q.push_back(8'($urandom));
    byte_q.push_back(8'($urandom));
    exp_consumed = 2 * cnt + ((CSUM_EN && cnt > 0) ? 2 : 0);
    exp_err      = CSUM_EN && bad_csum && (cnt > 0);

    idx = 0; writes = 0; dones = 0; cyc = 0; post = 0; last_wr = -10; last_acc = -10;
    stop = 0; rst_hit = 0;
    @(negedge clock);
    base_addr  = ADDR_W'(base);
    word_count = (ADDR_W+1)'(cnt);
    start      = 1'b1;
    byte_valid = 1'b0;
    @(negedge clock);
    start      = 1'b0;
    base_addr  = ADDR_W'($urandom);
    word_count = (ADDR_W+1)'($urandom);
    check({name, ".csum_err_cleared"}, csum_err, 0);

    while (!stop && cyc < 2000) begin
      if (ram_load) begin
        check({name, ".bytes_before_write"}, idx >= 2 * (writes + 1), 1);
        if (exp_addr_q.size() > 0) begin
          check({name, ".wr_addr"}, ram_addr, exp_addr_q.pop_front());
          check({name, ".wr_data"}, ram_in, exp_data_q.pop_front());
        end else begin
          check({name, ".spurious_write"}, 1, 0);
        end
        writes++;
        last_wr = cyc;
        if (writes == rst_after) begin
          rst_hit = 1;
          stop    = 1;
        end
      end
      if (done) begin
        dones++;
        if (dones == 1) begin
          ref_cyc = (cnt == 0) ? 0 : (CSUM_EN ? last_acc + 1 : last_wr + 1);
          check({name, ".done_cycle"}, cyc, ref_cyc);
          check({name, ".busy_with_done"}, busy, 1);
          check({name, ".csum_err_at_done"}, csum_err, exp_err);
        end
      end
      if (dones > 0) post++;
      if (post >= 3) stop = 1;
      if (!rst_hit) begin
        if (idx < byte_q.size() && $urandom_range(99) >= gap_pct) begin
          byte_valid = 1'b1;
          byte_data  = byte_q[idx];
          if (byte_ready) begin
            idx++;
            last_acc = cyc;
          end
        end else begin
          byte_valid = 1'b0;
          byte_data  = 8'($urandom);
        end
        start = mid_start && (cyc == 4);
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    check({name, ".finished_in_budget"}, stop, 1);

    if (rst_after > 0) begin
      check({name, ".reset_point_reached"}, rst_hit, 1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check({name, ".outs_zero_on_reset"}, all_outs(), 0);
      @(negedge clock);
      reset      = 1'b0;
      byte_valid = 1'b1;
      quiet      = 1;
      repeat (8) begin
        @(negedge clock);
        if (ram_load || byte_ready || busy || done) quiet = 0;
      end
      byte_valid = 1'b0;
      check({name, ".quiet_after_reset"}, quiet, 1);
      check({name, ".writes_before_reset"}, writes, rst_after);
    end else begin
      byte_valid = 1'b0;
      check({name, ".write_count"}, writes, cnt);
      check({name, ".done_pulses"}, dones, 1);
      check({name, ".bytes_consumed"}, idx, exp_consumed);
      check({name, ".busy_after"}, busy, 0);
      check({name, ".csum_err_held"}, csum_err, exp_err);
    end
    $display("[TB] %s base=%0d words=%0d writes=%0d consumed=%0d done=%0d csum_err=%0b",
             name, base, cnt, writes, idx, dones, csum_err);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #1;
    check("reset_outs", all_outs(), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    words_q = '{16'h1234, 16'hABCD};
    run_load("basic", 100, 0, 0, 0, -1);

    words_q = '{16'h0001, 16'h0002};
    run_load("wrap", DEPTH - 1, 0, 0, 0, -1);

    words_q = '{16'h1234, 16'hABCD};
    run_load("basic_gaps_restart", 100, 40, 1, 0, -1);

    words_q.delete();
    for (int i = 0; i < 6; i++) words_q.push_back(16'($urandom));
    run_load("random_gaps_restart", $urandom_range(DEPTH - 1), 50, 1, 0, -1);

    words_q.delete();
    run_load("zero_count", 200, 0, 0, 0, -1);

    words_q.delete();
    for (int i = 0; i < 4; i++) words_q.push_back(16'($urandom));
    run_load("reset_mid_load", 300, 20, 0, 0, 2);

    words_q = '{16'h1234, 16'hABCD};
    run_load("bad_checksum", 100, 0, 0, 1, -1);

    for (int t = 0; t < 4; t++) begin
      words_q.delete();
      for (int i = 0; i < $urandom_range(1, 8); i++) words_q.push_back(16'($urandom));
      run_load("random", DEPTH - 1 - $urandom_range(6), $urandom_range(60), 0, t[0], -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
